perm_cost_gen: RTL and testbench

- Source side of the job-assignment cost stream. Enumerates every permutation of N jobs over N workers in lexicographic order.
- For each permutation it issues (worker, job) addresses to the cost ROM and forwards the returned costs as a gap-free stream: N beats per permutation, back-to-back.
- Flags the final beat of the final permutation with Last. Feeds the downstream min-cost accumulator, which frames on fixed N-beat boundaries.

---
 rtl/jobs_pkg.sv | 19 +
 rtl/next_perm.sv | 47 ++++
 rtl/perm_cost_gen.sv | 165 ++++++++++++++++
 tb/tb_perm_cost_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jobs_pkg.sv
// jobs_pkg: shared constants, types and FSM state encoding for the
// permutation cost generator (perm_cost_gen) and its next_perm helper.
package jobs_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned COST_W = 7;
    localparam int unsigned IDX_W  = 16;

    typedef logic [$clog2(N)-1:0] idx_t;
    typedef idx_t [N-1:0]         perm_t;
    typedef logic [COST_W-1:0]    cost_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } gen_state_e;

endpackage

// File: rtl/next_perm.sv
// next_perm: purely combinational lexicographic successor of a permutation.
// is_last is high when the input is fully descending; next is then don't-care.
module next_perm #(
    parameter int unsigned N = jobs_pkg::N
) (
    input  logic [N-1:0][$clog2(N)-1:0] perm,
    output logic [N-1:0][$clog2(N)-1:0] next,
    output logic                        is_last
);

    localparam int unsigned IW = $clog2(N);
    typedef logic [IW-1:0] sel_t;

    logic [N-1:0][IW-1:0] swapped;
    int unsigned          piv;
    int unsigned          succ;
    logic                 found;

    // pivot search, successor search, swap, then reverse the tail
    always_comb begin
        piv   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i + 1 < N; i++) begin
            if (perm[sel_t'(i)] < perm[sel_t'(i + 1)]) begin
                piv   = i;
                found = 1'b1;
            end
        end
        succ = piv;
        for (int unsigned k = 0; k < N; k++) begin
            if (k > piv && perm[sel_t'(k)] > perm[sel_t'(piv)]) begin
                succ = k;
            end
        end
        swapped                = perm;
        swapped[sel_t'(piv)]   = perm[sel_t'(succ)];
        swapped[sel_t'(succ)]  = perm[sel_t'(piv)];
        next = swapped;
        for (int unsigned j = 0; j < N; j++) begin
            if (j > piv) begin
                next[sel_t'(j)] = swapped[sel_t'(N + piv - j)];
            end
        end
        is_last = !found;
    end

endmodule

// File: rtl/perm_cost_gen.sv
// perm_cost_gen: enumerates all N! permutations in lexicographic order,
// addresses the cost ROM with (worker, job) pairs and forwards the returned
// costs as a gap-free beat stream, N beats per permutation.
// Optional feature macro: PERM_INDEX_EN adds the perm_idx tag output.
module perm_cost_gen #(
    parameter int unsigned N      = jobs_pkg::N,
    parameter int unsigned COST_W = jobs_pkg::COST_W
`ifdef PERM_INDEX_EN
    ,
    parameter int unsigned IDX_W  = jobs_pkg::IDX_W
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    output logic [$clog2(N)-1:0] W,
    output logic [$clog2(N)-1:0] J,
    input  logic [COST_W-1:0]    rom_cost,
    output logic [COST_W-1:0]    cost,
    output logic                 cost_vld,
    output logic                 Last,
    output logic                 Busy
`ifdef PERM_INDEX_EN
    ,
    output logic [IDX_W-1:0]     perm_idx
`endif
);

    import jobs_pkg::*;

    localparam int unsigned IW = $clog2(N);
    typedef logic [IW-1:0] addr_t;
    typedef addr_t [N-1:0] order_t;

    function automatic order_t identity();
        order_t r;
        for (int unsigned i = 0; i < N; i++) r[addr_t'(i)] = addr_t'(i);
        return r;
    endfunction

    gen_state_e          state_q, state_d;
    addr_t               beat_q, beat_d;
    order_t              perm_q, perm_d;
    addr_t               w_hold_q, w_hold_d;
    addr_t               j_hold_q, j_hold_d;
    logic                rom_vld_q, rom_vld_d;
    logic                rom_last_q, rom_last_d;
    logic [COST_W-1:0]   cost_q, cost_d;
    logic                cost_vld_q, cost_vld_d;
    logic                last_q, last_d;
`ifdef PERM_INDEX_EN
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    rom_idx_q, rom_idx_d;
    logic [IDX_W-1:0]    perm_idx_q, perm_idx_d;
`endif

    order_t nxt_perm;
    logic   perm_is_last;
    logic   issue;
    logic   frame_end;

    next_perm #(.N(N)) u_next (
        .perm    (perm_q),
        .next    (nxt_perm),
        .is_last (perm_is_last)
    );

    // state and datapath registers, asynchronously cleared
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            perm_q     <= identity();
            w_hold_q   <= '0;
            j_hold_q   <= '0;
            rom_vld_q  <= 1'b0;
            rom_last_q <= 1'b0;
            cost_q     <= '0;
            cost_vld_q <= 1'b0;
            last_q     <= 1'b0;
`ifdef PERM_INDEX_EN
            idx_q      <= '0;
            rom_idx_q  <= '0;
            perm_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            perm_q     <= perm_d;
            w_hold_q   <= w_hold_d;
            j_hold_q   <= j_hold_d;
            rom_vld_q  <= rom_vld_d;
            rom_last_q <= rom_last_d;
            cost_q     <= cost_d;
            cost_vld_q <= cost_vld_d;
            last_q     <= last_d;
`ifdef PERM_INDEX_EN
            idx_q      <= idx_d;
            rom_idx_q  <= rom_idx_d;
            perm_idx_q <= perm_idx_d;
`endif
        end
    end

    // next-state: run until the descending permutation's last beat, then drain
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = STREAM;
            STREAM:  if (frame_end && perm_is_last) state_d = DRAIN;
            DRAIN:   if (last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // address issue, permutation stepping and the two-stage return pipeline
    always_comb begin
        issue     = (state_q == STREAM);
        frame_end = (beat_q == addr_t'(N - 1));

        // addresses are live from the counters while streaming, held otherwise
        W        = issue ? beat_q : w_hold_q;
        J        = issue ? perm_q[beat_q] : j_hold_q;
        w_hold_d = W;
        j_hold_d = J;

        beat_d = beat_q;
        perm_d = perm_q;
`ifdef PERM_INDEX_EN
        idx_d  = idx_q;
`endif
        if (state_q == IDLE && Start) begin
            beat_d = '0;
            perm_d = identity();
`ifdef PERM_INDEX_EN
            idx_d  = '0;
`endif
        end else if (issue) begin
            beat_d = frame_end ? '0 : beat_q + 1'b1;
            if (frame_end && !perm_is_last) begin
                perm_d = nxt_perm;
`ifdef PERM_INDEX_EN
                idx_d  = idx_q + 1'b1;
`endif
            end
        end

        rom_vld_d  = issue;
        rom_last_d = issue && frame_end && perm_is_last;
        cost_vld_d = rom_vld_q;
        last_d     = rom_last_q;
        cost_d     = rom_vld_q ? rom_cost : cost_q;
`ifdef PERM_INDEX_EN
        rom_idx_d  = idx_q;
        perm_idx_d = rom_vld_q ? rom_idx_q : perm_idx_q;
        perm_idx   = perm_idx_q;
`endif

        cost     = cost_q;
        cost_vld = cost_vld_q;
        Last     = last_q;
        Busy     = (state_q != IDLE);
    end

endmodule

// File: tb/tb_perm_cost_gen.sv
// tb_perm_cost_gen: three generator instances (N=8, 3, 5) each with its own
// registered ROM model, checked every cycle against a permutation model that
// derives the k-th lexicographic permutation from its factorial-base digits.
module tb_perm_cost_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start [3] = '{1'b0, 1'b0, 1'b0};

    logic [6:0] cost_o [3];
    logic       vld_o  [3];
    logic       last_o [3];
    logic       busy_o [3];

    int beats_cnt [3] = '{0, 0, 0};
    int last_cnt  [3] = '{0, 0, 0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic int fact(int n);
        int r = 1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    // element at position pos of the p-th (0-based) lexicographic permutation of 0..n-1
    function automatic int perm_elem(int n, int p, int pos);
        int avail[$];
        int f, d, r;
        for (int i = 0; i < n; i++) avail.push_back(i);
        r = p;
        for (int q = 0; q <= pos; q++) begin
            f = fact(n - 1 - q);
            d = r / f;
            r = r % f;
            if (q == pos) return avail[d];
            avail.delete(d);
        end
        return -1;
    endfunction

    function automatic int rom_rule(int g, int w, int j);
        return (g == 1) ? j + 1 : 8 * w + j;
    endfunction

    function automatic void chk(int id, string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL n=%0d %s: got %0d expected %0d", id, nm, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NN = (g == 0) ? 8 : (g == 1) ? 3 : 5;
        localparam int T  = NN * fact(NN);

        logic [$clog2(NN)-1:0] w, j;
        logic [6:0]            rom;
`ifdef PERM_INDEX_EN
        logic [15:0]           pidx;
`endif
        int k   = 0;
        bit run = 1'b0;
        int wh  = 0;
        int jh  = 0;

        perm_cost_gen #(.N(NN), .COST_W(7)) u_dut (
            .CLK      (clk),
            .RST      (rst),
            .Start    (start[g]),
            .W        (w),
            .J        (j),
            .rom_cost (rom),
            .cost     (cost_o[g]),
            .cost_vld (vld_o[g]),
            .Last     (last_o[g]),
            .Busy     (busy_o[g])
`ifdef PERM_INDEX_EN
            ,
            .perm_idx (pidx)
`endif
        );

        always @(posedge clk) rom <= 7'(rom_rule(g, int'(w), int'(j)));

        // model timeline: k counts edges since the run was accepted
        always @(posedge clk) begin
            if (rst) begin
                run = 1'b0;
            end else if (run) begin
                k++;
                if (k == T + 2) run = 1'b0;
            end else if (start[g]) begin
                run = 1'b1;
                k   = 0;
            end
        end

        always @(negedge clk) begin
            int m;
            if (rst) begin
                wh = 0;
                jh = 0;
                chk(NN, "rst_vld",  vld_o[g], 0);
                chk(NN, "rst_last", last_o[g], 0);
                chk(NN, "rst_busy", busy_o[g], 0);
                chk(NN, "rst_cost", cost_o[g], 0);
                chk(NN, "rst_w", int'(w), 0);
                chk(NN, "rst_j", int'(j), 0);
`ifdef PERM_INDEX_EN
                chk(NN, "rst_perm_idx", pidx, 0);
`endif
            end else begin
                chk(NN, "busy", busy_o[g], run);
                chk(NN, "cost_vld", vld_o[g], run && k >= 2);
                chk(NN, "last", last_o[g], run && k == T + 1);
                if (run && k >= 2) begin
                    m = k - 2;
                    chk(NN, "cost", cost_o[g],
                        rom_rule(g, m % NN, perm_elem(NN, m / NN, m % NN)));
`ifdef PERM_INDEX_EN
                    chk(NN, "perm_idx", pidx, m / NN);
`endif
                end
                if (vld_o[g]) beats_cnt[g]++;
                if (last_o[g]) last_cnt[g]++;
                if (run && k < T) begin
                    wh = k % NN;
                    jh = perm_elem(NN, k / NN, k % NN);
                end
                chk(NN, "w", int'(w), wh);
                chk(NN, "j", int'(j), jh);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(int id, int lim);
        int c = 0;
        while (busy_o[id] && c < lim) begin
            tick();
            c++;
        end
        chk(id, "done_in_time", busy_o[id], 0);
    endtask

    task automatic wait_beats(int id, int base, int n, int lim);
        int c = 0;
        while (beats_cnt[id] - base < n && c < lim) begin
            tick();
            c++;
        end
        chk(id, "beats_reached", beats_cnt[id] - base >= n, 1);
    endtask

    int lit [24] = '{0, 9, 18, 27, 36, 45, 54, 63,
                     0, 9, 18, 27, 36, 45, 55, 62,
                     0, 9, 18, 27, 36, 46, 53, 63};
    int b0, l0, b1, l1, b2, l2;

    initial begin
        // pin the permutation model against hand-derived values
        chk(0, "pin_fact8", fact(8), 40320);
        chk(0, "pin_p1_6", perm_elem(8, 1, 6), 7);
        chk(0, "pin_p1_7", perm_elem(8, 1, 7), 6);
        chk(0, "pin_p2_5", perm_elem(8, 2, 5), 6);
        chk(0, "pin_p2_6", perm_elem(8, 2, 6), 5);
        chk(0, "pin_n3_p3_0", perm_elem(3, 3, 0), 1);
        chk(0, "pin_n3_p3_1", perm_elem(3, 3, 1), 2);
        chk(0, "pin_n3_p3_2", perm_elem(3, 3, 2), 0);
        chk(0, "pin_last_0", perm_elem(8, 40319, 0), 7);
        chk(0, "pin_last_7", perm_elem(8, 40319, 7), 0);

        // Start while reset is held must be ignored
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk(8, "idle_after_rst_busy", busy_o[0], 0);

        // run N=8 (first frames) and N=3 (complete run)
        b1 = beats_cnt[1];
        l1 = last_cnt[1];
        start[0] = 1'b1;
        start[1] = 1'b1;
        tick();
        start[0] = 1'b0;
        start[1] = 1'b0;
        b0 = beats_cnt[0];
        tick();
        tick();
        for (int i = 0; i < 24; i++) begin
            chk(8, "first_frames_cost", cost_o[0], lit[i]);
            chk(8, "first_frames_vld", vld_o[0], 1);
            tick();
        end
        wait_idle(1, 200);
        chk(3, "run_beats", beats_cnt[1] - b1, 18);
        chk(3, "run_lasts", last_cnt[1] - l1, 1);

        // asynchronous reset mid-cycle around beat 500
        wait_beats(0, b0, 500, 2000);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk(8, "async_rst_vld", vld_o[0], 0);
        chk(8, "async_rst_busy", busy_o[0], 0);
        chk(8, "async_rst_cost", cost_o[0], 0);
        chk(8, "async_rst_last", last_o[0], 0);
        chk(8, "async_rst_w", int'(g_dut[0].w), 0);
        chk(8, "async_rst_j", int'(g_dut[0].j), 0);
        tick();
        rst = 1'b0;
        tick();

        // restart N=8 from identity, and run N=5 to completion
        b0 = beats_cnt[0];
        l0 = last_cnt[0];
        b2 = beats_cnt[2];
        l2 = last_cnt[2];
        start[0] = 1'b1;
        start[2] = 1'b1;
        tick();
        start[0] = 1'b0;
        start[2] = 1'b0;
        tick();
        tick();
        chk(8, "restart_first_cost", cost_o[0], 0);
        chk(8, "restart_first_vld", vld_o[0], 1);
`ifdef PERM_INDEX_EN
        chk(8, "restart_perm_idx", g_dut[0].pidx, 0);
`endif
        wait_idle(2, 800);
        chk(5, "run_beats", beats_cnt[2] - b2, 600);
        chk(5, "run_lasts", last_cnt[2] - l2, 1);

        // Start while busy at beat 1000 must not disturb the stream
        wait_beats(0, b0, 1000, 2000);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (100) tick();
        chk(8, "still_busy", busy_o[0], 1);
        chk(8, "no_early_last", last_cnt[0] - l0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
